// File: rtl/freq_readout.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : freq_readout                                                    |
// | Purpose  : Turns successive snapshots of a free-running cycle counter into |
// |            a per-interval delta (freq_count) and transmits each delta as   |
// |            a LENGTH-bit MSB-first serial frame. A one-deep pending buffer  |
// |            absorbs a delta that arrives while a frame is still shifting;   |
// |            overwriting an untransmitted delta sets a sticky overrun flag.  |
// | Ports    : clk_i            - single clock, all state on posedge           |
// |            reset_i          - synchronous, active-high                     |
// |            sample_strobe_i  - one-cycle pulse, cycle_count_i is fresh      |
// |            cycle_count_i    - counter snapshot from upstream               |
// |            ser_hold_i       - pause the serial shifter, hold current bit   |
// |            freq_count_o     - last computed delta                          |
// |            freq_valid_o     - one-cycle pulse, freq_count_o just updated   |
// |            ser_data_o       - frame bit (0 when no frame)                  |
// |            ser_frame_o      - high while a frame bit is presented          |
// |            overrun_o        - sticky, pending delta was overwritten        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module freq_readout #(
  parameter int LENGTH = 20
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              sample_strobe_i,
  input  logic [LENGTH-1:0] cycle_count_i,
  input  logic              ser_hold_i,
  output logic [LENGTH-1:0] freq_count_o,
  output logic              freq_valid_o,
  output logic              ser_data_o,
  output logic              ser_frame_o,
  output logic              overrun_o
);

  localparam int              CNT_W    = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(LENGTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,  // no previous sample yet
    ARMED = 2'd1,  // previous sample held, shifter idle
    SHIFT = 2'd2   // frame in progress
  } state_e;

  state_e            state_q,  state_d;
  logic [LENGTH-1:0] prev_q,   prev_d;
  logic [LENGTH-1:0] freq_q,   freq_d;
  logic [LENGTH-1:0] pend_q,   pend_d;
  logic              pend_v_q, pend_v_d;
  logic [LENGTH-1:0] shreg_q,  shreg_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic              valid_q,  valid_d;
  logic              data_q,   data_d;
  logic              frame_q,  frame_d;
  logic              ovr_q,    ovr_d;

  logic [LENGTH-1:0] delta;
  logic              load_en;
  logic [LENGTH-1:0] load_val;

  // Modular subtraction gives the correct interval across counter wrap.
  assign delta = cycle_count_i - prev_q;

  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    freq_d   = freq_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    valid_d  = 1'b0;
    data_d   = data_q;
    frame_d  = frame_q;
    ovr_d    = ovr_q;
    load_en  = 1'b0;
    load_val = pend_q;

    // Any strobe after the first sample publishes a new delta.
    if (state_q != EMPTY && sample_strobe_i) begin
      prev_d  = cycle_count_i;
      freq_d  = delta;
      valid_d = 1'b1;
    end

    case (state_q)
      EMPTY: begin
        if (sample_strobe_i) begin
          prev_d  = cycle_count_i;
          state_d = ARMED;
        end
      end

      ARMED: begin
        if (pend_v_q) begin
          // Buffered delta goes out first; a simultaneous strobe refills
          // the buffer rather than counting as an overrun.
          load_en  = 1'b1;
          load_val = pend_q;
          if (sample_strobe_i) begin
            pend_d = delta;
          end else begin
            pend_v_d = 1'b0;
          end
        end else if (sample_strobe_i) begin
          load_en  = 1'b1;
          load_val = delta;
        end
      end

      SHIFT: begin
        if (sample_strobe_i) begin
          if (pend_v_q) begin
            ovr_d = 1'b1;
          end
          pend_d   = delta;
          pend_v_d = 1'b1;
        end
        if (!ser_hold_i) begin
          if (cnt_q == LAST_BIT) begin
            frame_d = 1'b0;
            data_d  = 1'b0;
            cnt_d   = '0;
            state_d = ARMED;
          end else begin
            cnt_d   = cnt_q + CNT_ONE;
            data_d  = shreg_q[LENGTH-1];
            shreg_d = shreg_q << 1;
          end
        end
      end

      default: begin
        state_d = EMPTY;
      end
    endcase

    // MSB is presented immediately; the shifter keeps the remaining bits
    // left-aligned so the next bit is always at the top.
    if (load_en) begin
      data_d  = load_val[LENGTH-1];
      shreg_d = load_val << 1;
      frame_d = 1'b1;
      cnt_d   = '0;
      state_d = SHIFT;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= EMPTY;
      prev_q   <= '0;
      freq_q   <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      shreg_q  <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      data_q   <= 1'b0;
      frame_q  <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      freq_q   <= freq_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      frame_q  <= frame_d;
      ovr_q    <= ovr_d;
    end
  end

  assign freq_count_o = freq_q;
  assign freq_valid_o = valid_q;
  assign ser_data_o   = data_q;
  assign ser_frame_o  = frame_q;
  assign overrun_o    = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_freq_readout.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_freq_readout                                                 |
// | Purpose  : Scoreboard bench for freq_readout (LENGTH=8). A reference       |
// |            model tracks samples, the pending slot and the transmitter      |
// |            timeline and queues expected deltas and frames; a monitor on    |
// |            the falling edge compares whatever the DUT presents.            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_freq_readout;

  localparam int L = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         sample_strobe;
  logic [L-1:0] cycle_count;
  logic         ser_hold;
  logic [L-1:0] freq_count;
  logic         freq_valid;
  logic         ser_data;
  logic         ser_frame;
  logic         overrun;

  always #5 clk = ~clk;

  freq_readout #(.LENGTH(L)) dut (
    .clk_i           (clk),
    .reset_i         (reset),
    .sample_strobe_i (sample_strobe),
    .cycle_count_i   (cycle_count),
    .ser_hold_i      (ser_hold),
    .freq_count_o    (freq_count),
    .freq_valid_o    (freq_valid),
    .ser_data_o      (ser_data),
    .ser_frame_o     (ser_frame),
    .overrun_o       (overrun)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [L-1:0] val;    // bits the monitor should collect (right-aligned)
    int           nbits;  // number of distinct bits presented
    int           ncyc;   // cycles with ser_frame high
    int           start;  // edge index at which the frame was loaded
  } frame_t;

  frame_t       exp_frames[$];
  logic [L-1:0] exp_freq_q[$];

  int           cyc       = 0;
  bit           m_have    = 0;
  bit           m_pend_v  = 0;
  bit           m_tx_on   = 0;
  bit           m_ovr     = 0;
  logic [L-1:0] m_prev    = '0;
  logic [L-1:0] m_pend    = '0;
  logic [L-1:0] m_freq    = '0;
  logic [L-1:0] m_tx_val  = '0;
  int           m_sent    = 0;
  int           m_cycles  = 0;
  int           m_start   = 0;

  task automatic tx_start(input logic [L-1:0] v);
    m_tx_on  = 1;
    m_tx_val = v;
    m_sent   = 0;
    m_cycles = 0;
    m_start  = cyc;
  endtask

  task automatic tx_finish(input logic [L-1:0] v, input int nb);
    frame_t f;
    f.val   = v;
    f.nbits = nb;
    f.ncyc  = m_cycles;
    f.start = m_start;
    exp_frames.push_back(f);
    m_tx_on = 0;
  endtask

  always @(posedge clk) begin : ref_model
    bit           was_on;
    logic [L-1:0] d;
    cyc++;
    was_on = m_tx_on;
    // Transmitter: each unheld cycle consumes one bit of the frame.
    if (m_tx_on) begin
      m_cycles++;
      if (!ser_hold) m_sent++;
      if (reset) tx_finish(m_tx_val >> (L - m_sent), m_sent);
      else if (m_sent == L) tx_finish(m_tx_val, L);
    end
    if (reset) begin
      m_have   = 0;
      m_pend_v = 0;
      m_ovr    = 0;
      m_prev   = '0;
      m_freq   = '0;
    end else if (!m_have) begin
      if (sample_strobe) begin
        m_have = 1;
        m_prev = cycle_count;
      end
    end else begin
      d = cycle_count - m_prev;
      if (sample_strobe) begin
        m_prev = cycle_count;
        m_freq = d;
        exp_freq_q.push_back(d);
      end
      if (!was_on) begin
        // Idle transmitter: buffered value first, else a fresh delta.
        if (m_pend_v) begin
          tx_start(m_pend);
          if (sample_strobe) m_pend = d;
          else m_pend_v = 0;
        end else if (sample_strobe) begin
          tx_start(d);
        end
      end else if (sample_strobe) begin
        if (m_pend_v) m_ovr = 1;
        m_pend   = d;
        m_pend_v = 1;
      end
    end
  end

  // ---------------- monitor ----------------
  logic [L-1:0] obs_bits  = '0;
  int           obs_n     = 0;
  int           obs_cyc   = 0;
  int           obs_start = 0;
  bit           in_frame  = 0;

  always @(negedge clk) begin : monitor
    frame_t e;
    check("overrun", overrun, m_ovr);
    check("freq_count level", freq_count, m_freq);
    if (freq_valid) begin
      check("freq_valid expected", exp_freq_q.size() > 0, 1);
      if (exp_freq_q.size() > 0) check("freq_valid value", freq_count, exp_freq_q.pop_front());
    end
    if (ser_frame) begin
      if (!in_frame) begin
        in_frame  = 1;
        obs_n     = 0;
        obs_cyc   = 0;
        obs_bits  = '0;
        obs_start = cyc;
      end
      obs_cyc++;
      // A bit is consumed on the next edge only if hold is low now.
      if (!ser_hold) begin
        obs_bits = {obs_bits[L-2:0], ser_data};
        obs_n++;
      end
    end else begin
      check("ser_data idle", ser_data, 0);
      if (in_frame) begin
        in_frame = 0;
        check("frame expected", exp_frames.size() > 0, 1);
        if (exp_frames.size() > 0) begin
          e = exp_frames.pop_front();
          check("frame data", obs_bits, e.val);
          check("frame bits", obs_n, e.nbits);
          check("frame cycles", obs_cyc, e.ncyc);
          check("frame start", obs_start, e.start);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic strobe(input int v);
    sample_strobe = 1'b1;
    cycle_count   = v[L-1:0];
    tick();
    sample_strobe = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    reset         = 1'b1;
    sample_strobe = 1'b0;
    cycle_count   = '0;
    ser_hold      = 1'b0;
    idle(3);
    @(negedge clk);
    check("reset freq_count", freq_count, 0);
    check("reset freq_valid", freq_valid, 0);
    check("reset ser_frame", ser_frame, 0);
    check("reset ser_data", ser_data, 0);
    check("reset overrun", overrun, 0);
    tick();
    reset = 1'b0;

    // First sample silent, second yields 40 = 00101000.
    strobe(10);
    idle(3);
    strobe(50);
    @(negedge clk);
    check("delta 50-10", freq_count, 40);
    check("valid pulse", freq_valid, 1);
    idle(12);

    // Wrap: 250 -> 4 gives 10.
    strobe(250);
    idle(12);
    strobe(4);
    @(negedge clk);
    check("wrap delta", freq_count, 10);
    idle(12);

    // Two strobes during one frame: 5 then 7 -> overrun, 7 transmitted.
    strobe(9);
    strobe(14);
    tick();
    strobe(21);
    idle(20);
    @(negedge clk);
    check("overrun sticky", overrun, 1);

    // Hold at bit 4 for three cycles.
    do_reset();
    strobe(20);
    strobe(201);
    idle(4);
    ser_hold = 1'b1;
    idle(3);
    ser_hold = 1'b0;
    idle(12);

    // Zero delta is transmitted like any other.
    strobe(201);
    idle(12);

    // Strobe on the edge the pending delta is loaded.
    do_reset();
    strobe(100);
    strobe(103);
    strobe(110);
    idle(7);
    strobe(130);
    idle(30);
    @(negedge clk);
    check("no overrun on refill", overrun, 0);

    // Reset at bit 3 of a frame with a delta pending.
    do_reset();
    strobe(40);
    strobe(90);
    strobe(95);
    idle(2);
    do_reset();
    @(negedge clk);
    check("frame ends on reset", ser_frame, 0);
    strobe(200);
    idle(12);

    // Randomised traffic.
    for (int i = 0; i < 500; i++) begin
      sample_strobe = ($urandom_range(0, 5) == 0);
      cycle_count   = L'($urandom_range(0, 255));
      ser_hold      = ($urandom_range(0, 7) == 0);
      reset         = ($urandom_range(0, 199) == 0);
      tick();
    end
    sample_strobe = 1'b0;
    ser_hold      = 1'b0;
    reset         = 1'b0;
    idle(40);

    @(negedge clk);
    check("leftover freq expectations", exp_freq_q.size(), 0);
    check("leftover frame expectations", exp_frames.size(), 0);
    check("frame still open", in_frame, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
